step_phase_decoder: RTL and testbench

Monitors the four stepper coil phase lines (A, B, nA, nB) and decodes them back into motion: phase index, direction, a signed half-step position count, and fault/stall flags. It sits at the receiving end of the motor phase interface. It can be looped back onto the motor driver outputs for self-check, or wired to external phase lines to track another controller's stepper. It runs on the 125 MHz system clock; the phase inputs are asynchronous to it.

---
 rtl/step_phase_decoder_if.sv | 29 ++
 rtl/step_phase_decoder.sv | 194 +++++++++++++++++++
 tb/tb_step_phase_decoder.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/step_phase_decoder_if.sv
// Phase-line and decoded-motion bundle for step_phase_decoder.
// master drives the coil lines and clear strobes; slave is the decoder.
interface step_phase_decoder_if #(
    parameter int unsigned POS_W = 16
);
    logic                    in_A;
    logic                    in_B;
    logic                    in_nA;
    logic                    in_nB;
    logic                    pos_clr;
    logic                    fault_clr;
    logic                    step_pulse;
    logic                    dir;
    logic signed [POS_W-1:0] position;
    logic [2:0]              phase;
    logic                    idle;
    logic                    fault;
    logic                    stalled;

    modport master (
        output in_A, in_B, in_nA, in_nB, pos_clr, fault_clr,
        input  step_pulse, dir, position, phase, idle, fault, stalled
    );

    modport slave (
        input  in_A, in_B, in_nA, in_nB, pos_clr, fault_clr,
        output step_pulse, dir, position, phase, idle, fault, stalled
    );
endinterface

// File: rtl/step_phase_decoder.sv
// Decodes asynchronous stepper coil lines into phase, direction, half-step position and fault flags.
// Optional stall timeout is enabled by defining STEP_DEC_TIMEOUT_EN.
module step_phase_decoder #(
    parameter int unsigned POS_W      = 16,
    parameter int unsigned STABLE_CYC = 4,
    parameter int unsigned TIMEOUT    = 125000
) (
    input  logic                 clk,
    input  logic                 rst,
    step_phase_decoder_if.slave  bus
);

    localparam int unsigned CNT_W = 8;

    if (STABLE_CYC < 1 || STABLE_CYC > 255 || TIMEOUT < 1) begin : g_param_check
        $error("step_phase_decoder: STABLE_CYC must be 1..255 and TIMEOUT at least 1");
    end

    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       acc_q, acc_d;
    logic             ref_q, ref_d;
    logic [2:0]       phase_q, phase_d;
    logic             dir_q, dir_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             idle_q, idle_d;
    logic             fault_q, fault_d;
    logic             step_q, step_d;

    logic [3:0]       code_c;
    logic [CNT_W-1:0] stable_len_c;
    logic             accept_c;
    logic             code_legal_c;
    logic [2:0]       code_idx_c;
    logic [2:0]       delta_c;
    logic             new_fault_c;

    assign code_c = sync2_q;

    // Length of the current run of identical samples, saturating at STABLE_CYC
    always_comb begin
        if (code_c != prev_q) begin
            stable_len_c = CNT_W'(1);
        end else if (cnt_q >= CNT_W'(STABLE_CYC)) begin
            stable_len_c = cnt_q;
        end else begin
            stable_len_c = cnt_q + CNT_W'(1);
        end
        cnt_d    = stable_len_c;
        accept_c = (stable_len_c >= CNT_W'(STABLE_CYC)) && (code_c != acc_q);
    end

    always_comb begin
        code_legal_c = 1'b1;
        code_idx_c   = 3'd0;
        case (code_c)
            4'b1000: code_idx_c = 3'd0;
            4'b1100: code_idx_c = 3'd1;
            4'b0100: code_idx_c = 3'd2;
            4'b0110: code_idx_c = 3'd3;
            4'b0010: code_idx_c = 3'd4;
            4'b0011: code_idx_c = 3'd5;
            4'b0001: code_idx_c = 3'd6;
            4'b1001: code_idx_c = 3'd7;
            default: code_legal_c = 1'b0;
        endcase
    end

    assign delta_c = code_idx_c - phase_q;

    // Acceptance: idle, illegal, reference load, step or skip fault
    always_comb begin
        acc_d       = acc_q;
        ref_d       = ref_q;
        phase_d     = phase_q;
        dir_d       = dir_q;
        pos_d       = pos_q;
        idle_d      = idle_q;
        step_d      = 1'b0;
        new_fault_c = 1'b0;

        if (accept_c) begin
            acc_d = code_c;
            if (code_c == 4'b0000) begin
                idle_d = 1'b1;
                ref_d  = 1'b0;
            end else if (!code_legal_c) begin
                new_fault_c = 1'b1;
                ref_d       = 1'b0;
                idle_d      = 1'b0;
            end else begin
                idle_d  = 1'b0;
                ref_d   = 1'b1;
                phase_d = code_idx_c;
                if (ref_q) begin
                    case (delta_c)
                        3'd1, 3'd2: begin
                            step_d = 1'b1;
                            dir_d  = 1'b1;
                            pos_d  = pos_q + POS_W'(delta_c);
                        end
                        3'd6, 3'd7: begin
                            step_d = 1'b1;
                            dir_d  = 1'b0;
                            pos_d  = pos_q - POS_W'(4'd8 - {1'b0, delta_c});
                        end
                        default: new_fault_c = 1'b1;
                    endcase
                end
            end
        end

        if (bus.pos_clr) begin
            pos_d = '0;
        end
        fault_d = (fault_q & ~bus.fault_clr) | new_fault_c;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            ref_q   <= 1'b0;
            phase_q <= '0;
            dir_q   <= 1'b0;
            pos_q   <= '0;
            idle_q  <= 1'b1;
            fault_q <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            sync1_q <= {bus.in_A, bus.in_B, bus.in_nA, bus.in_nB};
            sync2_q <= sync1_q;
            prev_q  <= code_c;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ref_q   <= ref_d;
            phase_q <= phase_d;
            dir_q   <= dir_d;
            pos_q   <= pos_d;
            idle_q  <= idle_d;
            fault_q <= fault_d;
            step_q  <= step_d;
        end
    end

    assign bus.step_pulse = step_q;
    assign bus.dir        = dir_q;
    assign bus.position   = pos_q;
    assign bus.phase      = phase_q;
    assign bus.idle       = idle_q;
    assign bus.fault      = fault_q;

`ifdef STEP_DEC_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);

    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic               stalled_q, stalled_d;

    // Cycles since the last step while energized with a valid reference
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        stalled_d   = stalled_q;
        if (step_d || idle_d || !ref_d) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q != STALL_W'(TIMEOUT)) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
        if (step_d || idle_d) begin
            stalled_d = 1'b0;
        end else if (stall_cnt_d == STALL_W'(TIMEOUT)) begin
            stalled_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            stalled_q   <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            stalled_q   <= stalled_d;
        end
    end

    assign bus.stalled = stalled_q;
`else
    assign bus.stalled = 1'b0;
`endif

endmodule

// File: tb/tb_step_phase_decoder.sv
// Bench for step_phase_decoder: directed plan scenarios plus randomized coil codes against a window-based model.
module tb_step_phase_decoder;

    localparam int unsigned S   = 4;
    localparam int unsigned TMO = 100;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #4 clk = ~clk;

    step_phase_decoder_if #(.POS_W(16)) ifa ();
    step_phase_decoder_if #(.POS_W(4))  ifw ();

    step_phase_decoder #(.POS_W(16), .STABLE_CYC(S), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    step_phase_decoder #(.POS_W(4), .STABLE_CYC(S), .TIMEOUT(TMO)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (ifw)
    );

    localparam logic [3:0] PH [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                      4'b0010, 4'b0011, 4'b0001, 4'b1001};

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a code is taken once the last S synchronized samples agree
    logic [3:0] win [S+2];
    logic [3:0] m_acc;
    int  m_phase, m_pos, m_last, edge_n;
    bit  m_dir, m_idle, m_fault, m_ref, m_step, m_stalled;

    task automatic model_reset();
        for (int i = 0; i < int'(S) + 2; i++) win[i] = 4'b0000;
        m_acc = 4'b0000; m_phase = 0; m_pos = 0; m_last = edge_n;
        m_dir = 1'b0; m_idle = 1'b1; m_fault = 1'b0; m_ref = 1'b0;
        m_step = 1'b0; m_stalled = 1'b0;
    endtask

    task automatic model_edge();
        bit stable, nf;
        int idx, d, mv;
        for (int i = int'(S) + 1; i > 0; i--) win[i] = win[i-1];
        win[0] = {ifa.in_A, ifa.in_B, ifa.in_nA, ifa.in_nB};
        m_step = 1'b0; nf = 1'b0; mv = 0;
        stable = 1'b1;
        for (int j = 3; j <= int'(S) + 1; j++) if (win[j] != win[2]) stable = 1'b0;
        if (stable && win[2] != m_acc) begin
            m_acc = win[2];
            idx = -1;
            for (int i = 0; i < 8; i++) if (PH[i] == win[2]) idx = i;
            if (win[2] == 4'b0000) begin
                m_idle = 1'b1; m_ref = 1'b0;
            end else if (idx < 0) begin
                nf = 1'b1; m_ref = 1'b0; m_idle = 1'b0;
            end else begin
                m_idle = 1'b0;
                if (m_ref) begin
                    d = (idx - m_phase + 8) % 8;
                    if (d == 1 || d == 2) begin
                        mv = d; m_dir = 1'b1; m_step = 1'b1;
                    end else if (d == 6 || d == 7) begin
                        mv = d - 8; m_dir = 1'b0; m_step = 1'b1;
                    end else begin
                        nf = 1'b1;
                    end
                end
                m_phase = idx; m_ref = 1'b1;
            end
        end
        m_pos = m_pos + mv;
        if (ifa.pos_clr) m_pos = 0;
        m_fault = (m_fault && !ifa.fault_clr) || nf;
        if (m_step || m_idle || !m_ref) m_last = edge_n;
        if (m_step || m_idle) m_stalled = 1'b0;
        else if (edge_n - m_last >= int'(TMO)) m_stalled = 1'b1;
    endtask

    initial model_reset();

    // Single compare process: update model at the edge, compare 1 time unit later
    always @(posedge clk) begin
        logic signed [15:0] e16;
        logic signed [3:0]  e4;
        bit exp_stalled;
        edge_n++;
        if (!rst) model_reset();
        else model_edge();
        #1;
        e16 = 16'(m_pos);
        e4  = 4'(m_pos);
`ifdef STEP_DEC_TIMEOUT_EN
        exp_stalled = m_stalled;
`else
        exp_stalled = 1'b0;
`endif
        check("a.step_pulse", int'(ifa.step_pulse), int'(m_step));
        check("a.dir",        int'(ifa.dir),        int'(m_dir));
        check("a.position",   int'(ifa.position),   int'(e16));
        check("a.phase",      int'(ifa.phase),      m_phase);
        check("a.idle",       int'(ifa.idle),       int'(m_idle));
        check("a.fault",      int'(ifa.fault),      int'(m_fault));
        check("a.stalled",    int'(ifa.stalled),    int'(exp_stalled));
        check("w.position",   int'(ifw.position),   int'(e4));
        check("w.step_pulse", int'(ifw.step_pulse), int'(m_step));
        if (ifa.step_pulse) pulses++;
    end

    task automatic drive(input logic [3:0] c);
        {ifa.in_A, ifa.in_B, ifa.in_nA, ifa.in_nB} = c;
        {ifw.in_A, ifw.in_B, ifw.in_nA, ifw.in_nB} = c;
    endtask

    task automatic set_clr(input bit pc, input bit fc);
        ifa.pos_clr = pc; ifa.fault_clr = fc;
        ifw.pos_clr = pc; ifw.fault_clr = fc;
    endtask

    task automatic hold(input logic [3:0] c, input int n);
        drive(c);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(4'b0000);
        set_clr(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_step(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ifa.step_pulse) seen = 1'b1;
        end
        check({name, ".seen"}, int'(seen), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, p, r, n;
        logic [3:0] c;
        drive(4'b0000);
        set_clr(1'b0, 1'b0);
        do_reset();

        check("rst.position",   int'(ifa.position),   0);
        check("rst.phase",      int'(ifa.phase),      0);
        check("rst.idle",       int'(ifa.idle),       1);
        check("rst.fault",      int'(ifa.fault),      0);
        check("rst.dir",        int'(ifa.dir),        0);
        check("rst.step_pulse", int'(ifa.step_pulse), 0);
        check("rst.stalled",    int'(ifa.stalled),    0);

        // Forward half-step walk
        hold(PH[0], 10);
        p0 = pulses;
        for (int i = 1; i < 8; i++) hold(PH[i], 10);
        hold(PH[0], 10);
        check("fwd.pulses",   pulses - p0,          8);
        check("fwd.dir",      int'(ifa.dir),        1);
        check("fwd.position", int'(ifa.position),   8);
        check("fwd.phase",    int'(ifa.phase),      0);
        check("fwd.fault",    int'(ifa.fault),      0);

        // Reverse full-step two-phase
        do_reset();
        hold(4'b1100, 10);
        p0 = pulses;
        hold(4'b1001, 10); hold(4'b0011, 10); hold(4'b0110, 10); hold(4'b1100, 10);
        check("rev.pulses",   pulses - p0,        4);
        check("rev.dir",      int'(ifa.dir),      0);
        check("rev.position", int'(ifa.position), -8);

        // Glitch reject, then exact latency of an accepted step
        do_reset();
        hold(PH[0], 10);
        p0 = pulses;
        hold(4'b1100, 3);
        hold(PH[0], 10);
        check("glitch.pulses", pulses - p0,     0);
        check("glitch.phase",  int'(ifa.phase), 0);
        drive(4'b1100);
        repeat (5) @(negedge clk);
        check("lat.early", int'(ifa.step_pulse), 0);
        @(negedge clk);
        check("lat.pulse", int'(ifa.step_pulse), 1);
        check("lat.phase", int'(ifa.phase),      1);
        @(negedge clk);
        check("lat.width", int'(ifa.step_pulse), 0);

        // Illegal code, fault clear, skip fault
        do_reset();
        hold(PH[0], 10);
        p0 = pulses;
        hold(4'b1010, 10);
        check("ill.fault",  int'(ifa.fault), 1);
        check("ill.pulses", pulses - p0,     0);
        check("ill.idle",   int'(ifa.idle),  0);
        set_clr(1'b0, 1'b1);
        @(negedge clk);
        set_clr(1'b0, 1'b0);
        @(negedge clk);
        check("fclr.fault", int'(ifa.fault), 0);
        hold(PH[0], 10);
        hold(4'b0010, 10);
        check("skip.fault", int'(ifa.fault), 1);
        check("skip.phase", int'(ifa.phase), 4);
        hold(4'b0000, 10);
        check("idle.idle",  int'(ifa.idle),  1);
        check("idle.phase", int'(ifa.phase), 4);

        // Narrow-counter wrap and pos_clr against a same-cycle step
        do_reset();
        hold(PH[0], 10);
        for (int i = 1; i <= 9; i++) hold(PH[i % 8], 10);
        check("wrap.narrow", int'(ifw.position), -7);
        check("wrap.wide",   int'(ifa.position), 9);
        drive(PH[2]);
        repeat (5) @(negedge clk);
        set_clr(1'b1, 1'b0);
        @(negedge clk);
        set_clr(1'b0, 1'b0);
        check("pclr.pulse",  int'(ifa.step_pulse), 1);
        check("pclr.pos",    int'(ifa.position),   0);
        check("pclr.narrow", int'(ifw.position),   0);
        check("pclr.dir",    int'(ifa.dir),        1);

        // Stall timeout after the last step
        do_reset();
        hold(PH[0], 10);
        drive(PH[1]);
        wait_step("stall.step1");
        repeat (99) @(negedge clk);
        check("stall.before", int'(ifa.stalled), 0);
        @(negedge clk);
`ifdef STEP_DEC_TIMEOUT_EN
        check("stall.at", int'(ifa.stalled), 1);
`else
        check("stall.at", int'(ifa.stalled), 0);
`endif
        drive(PH[2]);
        wait_step("stall.step2");
        check("stall.clear", int'(ifa.stalled), 0);

        // Randomized coil codes, glitches, clears and one mid-run reset
        do_reset();
        p = 0;
        for (int it = 0; it < 300; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70) begin
                case ($urandom_range(0, 3))
                    0: p = (p + 1) % 8;
                    1: p = (p + 2) % 8;
                    2: p = (p + 6) % 8;
                    default: p = (p + 7) % 8;
                endcase
                c = PH[p];
            end else if (r < 78) begin
                c = 4'b0000;
            end else if (r < 86) begin
                p = (p + int'($urandom_range(3, 5))) % 8;
                c = PH[p];
            end else begin
                c = 4'($urandom_range(0, 15));
            end
            drive(c);
            n = int'($urandom_range(1, 9));
            for (int k = 0; k < n; k++) begin
                set_clr($urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0);
                @(negedge clk);
            end
            set_clr(1'b0, 1'b0);
            if (it == 150) begin
                #2 rst = 1'b0;
                repeat (2) @(negedge clk);
                rst = 1'b1;
            end
        end
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
